// File: rtl/mem_initiator.sv
// mem_initiator: burst bus master for a valid/ready single-port memory.
// Each accepted command becomes cmd_len+1 memory beats at consecutive
// (wrapping) addresses. Read beats are returned one at a time through a
// back-pressured response port. Every burst ends with a one-cycle done
// pulse, and err marks a burst that was aborted because a beat waited too
// long for ready.
//
// Handshake rule used on all three ports: a transfer happens on a rising
// clk edge where both valid and ready are high. The offering side holds its
// payload stable until that edge. ready seen while valid is low is ignored.
module mem_initiator #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  valid,
    input  logic                  ready,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // DONE is the single cycle in which done/err are shown before IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat;
    logic [TW-1:0]          tcnt;
    logic                   last_beat;
    logic                   timeout_hit;
    logic [ADDR_WIDTH-1:0]  addr_next;

    assign last_beat   = (beat == len_q);
    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
    assign addr_next   = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);

    // State register; reset abandons any burst without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = S_REQ;
            S_REQ: begin
                if (ready) begin
                    if (!wr_rd)         state_nxt = S_RSP;
                    else if (last_beat) state_nxt = S_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_RSP: if (rsp_ready) state_nxt = last_beat ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    // Registered bus, response and completion outputs plus beat/timeout counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            len_q     <= '0;
            beat      <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (cmd_valid) begin
                        valid <= 1'b1;
                        wr_rd <= cmd_wr;
                        addr  <= cmd_addr;
                        wdata <= cmd_wdata;
                        len_q <= cmd_len;
                        beat  <= '0;
                        tcnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (ready) begin
                        tcnt <= '0;
                        if (!wr_rd) begin
                            // Read beat: hand the data to the response port.
                            valid     <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata;
                            rsp_addr  <= addr;
                        end else if (last_beat) begin
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Write beats stream: valid stays high.
                            beat  <= beat + LEN_WIDTH'(1);
                            addr  <= addr_next;
                            wdata <= wdata + WIDTH'(1);
                        end
                    end else if (timeout_hit) begin
                        valid <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (last_beat) begin
                            done <= 1'b1;
                        end else begin
                            beat  <= beat + LEN_WIDTH'(1);
                            addr  <= addr_next;
                            wdata <= wdata + WIDTH'(1);
                            valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                end
                default: begin
                    valid     <= 1'b0;
                    rsp_valid <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge the design acts on.
module tb_mem_initiator;

    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_wdata = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [7:0]    rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          done;
    logic          err;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [32];
    logic [WIDTH-1:0] exp_q[$];

    mem_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .done(done), .err(err), .busy(busy)
    );

    // clock / memory model
    always #5 clk = ~clk;

    assign rdata = mem[addr];

    always @(posedge clk) begin
        if (rst && valid && ready && wr_rd) mem[addr] <= wdata;
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    end

    // Driver: offer one command at the current negedge, return at the next one.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [7:0] d, input logic [LW-1:0] l);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (valid !== 1'b0)     begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (addr !== 5'd0 || wdata !== 8'd0 || wr_rd !== 1'b0) begin n_bad++; $display("FAIL rst_bus: got a=%0d d=%0d w=%b want 0 0 0", addr, wdata, wr_rd); end
        n_cmp++; if (rsp_rdata !== 8'd0 || rsp_addr !== 5'd0) begin n_bad++; $display("FAIL rst_rsp_data: got %0d/%0d want 0/0", rsp_rdata, rsp_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        // reset in the middle of a stalled request
        ready = 1'b0;
        send_cmd(1'b1, 5'd3, 8'd1, 4'd0);
        n_cmp++; if (valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_req: got v=%b b=%b want 1 1", valid, busy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_rst: got v=%b b=%b want 0 0", valid, busy); end
        n_cmp++; if (done !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_done: got d=%b r=%b want 0 0", done, rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL after_rst: got cr=%b d=%b want 1 0", cmd_ready, done); end
    endtask

    task automatic test_single_write;
        ready = 1'b0;
        send_cmd(1'b1, 5'd10, 8'd100, 4'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (valid !== 1'b1 || wr_rd !== 1'b1) begin n_bad++; $display("FAIL single_valid c%0d: got v=%b w=%b want 1 1", i, valid, wr_rd); end
            n_cmp++; if (addr !== 5'd10 || wdata !== 8'd100) begin n_bad++; $display("FAIL single_bus c%0d: got a=%0d d=%0d want 10 100", i, addr, wdata); end
            n_cmp++; if (cmd_ready !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL single_status c%0d: got cr=%b d=%b want 0 0", i, cmd_ready, done); end
            if (i == 2) ready = 1'b1;
            @(negedge clk);
        end
        ready = 1'b0;
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL single_done: got d=%b e=%b v=%b want 1 0 0", done, err, valid); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL single_done_cr: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle: got d=%b b=%b cr=%b want 0 0 1", done, busy, cmd_ready); end
        n_cmp++; if (mem[10] !== 8'd100) begin n_bad++; $display("FAIL single_mem: got %0d want 100", mem[10]); end
    endtask

    task automatic test_write_wrap;
        logic [AW-1:0] exp_a[4];
        exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
        ready = 1'b1;
        send_cmd(1'b1, 5'd30, 8'd5, 4'd3);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (valid !== 1'b1 || addr !== exp_a[i] || wdata !== 8'(5 + i)) begin n_bad++; $display("FAIL wrap_beat%0d: got v=%b a=%0d d=%0d want 1 %0d %0d", i, valid, addr, wdata, exp_a[i], 5 + i); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wrap_early_done%0d: got %b want 0", i, done); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL wrap_done: got d=%b e=%b v=%b want 1 0 0", done, err, valid); end
        @(negedge clk);
        ready = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL wrap_single_pulse: got d=%b b=%b want 0 0", done, busy); end
    endtask

    task automatic test_read_stall;
        logic [AW-1:0] exp_a[4];
        logic [7:0] exp_d;
        int stall;
        exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
        exp_q.push_back(8'd5); exp_q.push_back(8'd6);
        exp_q.push_back(8'd7); exp_q.push_back(8'd8);
        ready = 1'b1;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 5'd30, 8'd0, 4'd3);
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (valid !== 1'b1 || wr_rd !== 1'b0 || addr !== exp_a[b]) begin n_bad++; $display("FAIL rd_req%0d: got v=%b w=%b a=%0d want 1 0 %0d", b, valid, wr_rd, addr, exp_a[b]); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_req_rsp%0d: got %b want 0", b, rsp_valid); end
            @(negedge clk);
            exp_d = exp_q.pop_front();
            stall = (b == 1) ? 3 : 0;
            for (int s = 0; s <= stall; s++) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d || rsp_addr !== exp_a[b]) begin n_bad++; $display("FAIL rd_rsp%0d.%0d: got rv=%b d=%0d a=%0d want 1 %0d %0d", b, s, rsp_valid, rsp_rdata, rsp_addr, exp_d, exp_a[b]); end
                n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_valid%0d.%0d: got %b want 0", b, s, valid); end
                rsp_ready = (s == stall);
                @(negedge clk);
            end
            rsp_ready = 1'b0;
        end
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || valid !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_done: got d=%b e=%b v=%b r=%b want 1 0 0 0", done, err, valid, rsp_valid); end
        @(negedge clk);
        ready = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got d=%b b=%b want 0 0", done, busy); end
    endtask

    task automatic test_timeout;
        ready = 1'b0;
        send_cmd(1'b1, 5'd3, 8'd40, 4'd2);
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (valid !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d: got v=%b d=%b want 1 0", i, valid, done); end
            @(negedge clk);
        end
        n_cmp++; if (valid !== 1'b0 || done !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL to_abort: got v=%b d=%b e=%b want 0 1 1", valid, done, err); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL to_idle: got d=%b e=%b b=%b cr=%b want 0 0 0 1", done, err, busy, cmd_ready); end
        // next command runs normally
        ready = 1'b1;
        send_cmd(1'b1, 5'd4, 8'd20, 4'd0);
        n_cmp++; if (valid !== 1'b1 || addr !== 5'd4 || wdata !== 8'd20) begin n_bad++; $display("FAIL to_next_beat: got v=%b a=%0d d=%0d want 1 4 20", valid, addr, wdata); end
        @(negedge clk);
        ready = 1'b0;
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL to_next_done: got d=%b e=%b want 1 0", done, err); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        ready = 1'b1;
        send_cmd(1'b1, 5'd7, 8'd50, 4'd1);
        // second command held while the first burst runs
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'd20; cmd_wdata = 8'd9; cmd_len = 4'd0;
        n_cmp++; if (cmd_ready !== 1'b0 || addr !== 5'd7 || wdata !== 8'd50) begin n_bad++; $display("FAIL bp_beat0: got cr=%b a=%0d d=%0d want 0 7 50", cmd_ready, addr, wdata); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0 || addr !== 5'd8 || wdata !== 8'd51) begin n_bad++; $display("FAIL bp_beat1: got cr=%b a=%0d d=%0d want 0 8 51", cmd_ready, addr, wdata); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || cmd_ready !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL bp_done: got d=%b cr=%b v=%b want 1 0 0", done, cmd_ready, valid); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got cr=%b v=%b d=%b want 1 0 0", cmd_ready, valid, done); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if (valid !== 1'b1 || addr !== 5'd20 || wdata !== 8'd9) begin n_bad++; $display("FAIL bp_second: got v=%b a=%0d d=%0d want 1 20 9", valid, addr, wdata); end
        @(negedge clk);
        ready = 1'b0;
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL bp_second_done: got d=%b e=%b want 1 0", done, err); end
        n_cmp++; if (mem[7] !== 8'd50 || mem[8] !== 8'd51 || mem[20] !== 8'd9) begin n_bad++; $display("FAIL bp_mem: got %0d %0d %0d want 50 51 9", mem[7], mem[8], mem[20]); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_wrap();
        test_read_stall();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard stop in case a scenario stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
